// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and constants for the register-file dump reader.
// REGFILE_DUMP_SKIP_ZERO_EN skips the hardwired-zero register 0.
package regfile_dump_reader_pkg;

    localparam int N        = 32;
    localparam int ADDR     = 5;
    localparam int NUM_REGS = 2 ** ADDR;

    localparam logic [ADDR-1:0] LAST_IDX = ADDR'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_SKIP_ZERO_EN
    localparam logic [ADDR-1:0] FIRST_IDX = ADDR'(1);
`else
    localparam logic [ADDR-1:0] FIRST_IDX = ADDR'(0);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks every register through a spare read port and streams each word out
// over valid/ready with its index. Honours REGFILE_DUMP_SKIP_ZERO_EN via the package.
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    output logic [ADDR-1:0] rf_addr_o,
    input  logic [N-1:0]    rf_data_i,
    output logic            dump_valid_o,
    input  logic            dump_ready_i,
    output logic [N-1:0]    dump_data_o,
    output logic [ADDR-1:0] dump_idx_o,
    output logic            busy_o,
    output logic            done_o
);

    state_e          state_q, state_d;
    logic [ADDR-1:0] idx_q, idx_d;
    logic            valid_q, valid_d;
    logic [N-1:0]    data_q, data_d;
    logic [ADDR-1:0] didx_q, didx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        data_d  = data_q;
        didx_d  = didx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    idx_d   = FIRST_IDX;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                data_d  = rf_data_i;
                didx_d  = idx_q;
                valid_d = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // Last-index test stops the counter before it can wrap to 0.
                if (valid_q && dump_ready_i) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            didx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            didx_q  <= didx_d;
        end
    end

    assign rf_addr_o    = idx_q;
    assign dump_valid_o = valid_q;
    assign dump_data_o  = data_q;
    assign dump_idx_o   = didx_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized/directed bench for regfile_dump_reader against a cycle-timed dump model.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_i;
    logic [ADDR-1:0] rf_addr_o;
    logic [N-1:0]    rf_data_i;
    logic            dump_valid_o;
    logic            dump_ready_i;
    logic [N-1:0]    dump_data_o;
    logic [ADDR-1:0] dump_idx_o;
    logic            busy_o;
    logic            done_o;

    logic [N-1:0] rf  [NUM_REGS];
    logic [N-1:0] got [NUM_REGS];

    int errors = 0;
    int checks = 0;

    // Model: a dump is a list of words; each word appears the cycle after its
    // fetch cycle, the next fetch follows an acceptance, done follows the last one.
    int           cyc = 0;
    bit           m_active = 0, m_valid = 0, m_done = 0;
    int           m_next = 0, m_fetch = -1, m_idx = 0;
    logic [N-1:0] m_data = '0;
    int           words = 0, dones = 0;

    regfile_dump_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .rf_addr_o    (rf_addr_o),
        .rf_data_i    (rf_data_i),
        .dump_valid_o (dump_valid_o),
        .dump_ready_i (dump_ready_i),
        .dump_data_o  (dump_data_o),
        .dump_idx_o   (dump_idx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    assign rf_data_i = rf[rf_addr_o];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input bit st, input bit rdy, input bit rst);
        bit           n_active = m_active, n_valid = m_valid, n_done = m_done, fresh = 0;
        int           n_next = m_next, n_fetch = m_fetch, n_idx = m_idx;
        logic [N-1:0] n_data = m_data;
        reset = rst; start_i = st; dump_ready_i = rdy;
        if (rst) begin
            n_active = 0; n_valid = 0; n_done = 0;
            n_next = 0; n_fetch = -1; n_idx = 0; n_data = '0;
        end else begin
            if (m_done) begin n_done = 0; n_active = 0; end
            if (!m_active && st) begin
                n_active = 1; n_next = int'(FIRST_IDX); n_fetch = cyc + 1;
            end
            if (m_active && m_fetch == cyc) begin
                chk("rf_addr_fetch", 64'(rf_addr_o), 64'(m_next));
                n_valid = 1; n_idx = m_next; n_data = rf[m_next]; n_fetch = -1; fresh = 1;
            end
            if (m_valid && rdy) begin
                n_valid = 0; words++;
                if (m_idx == int'(LAST_IDX)) n_done = 1;
                else begin n_next = m_idx + 1; n_fetch = cyc + 1; end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        m_active = n_active; m_valid = n_valid; m_done = n_done;
        m_next = n_next; m_fetch = n_fetch; m_idx = n_idx; m_data = n_data;
        chk("valid", 64'(dump_valid_o), 64'(m_valid));
        chk("done", 64'(done_o), 64'(m_done));
        chk("busy", 64'(busy_o), 64'(m_active));
        chk("valid_done_excl", 64'(dump_valid_o && done_o), 64'(0));
        if (m_valid) begin
            chk("data", 64'(dump_data_o), 64'(m_data));
            chk("idx", 64'(dump_idx_o), 64'(m_idx));
        end
        if (rst) begin
            chk("rst_rf_addr", 64'(rf_addr_o), 64'(0));
            chk("rst_data", 64'(dump_data_o), 64'(0));
            chk("rst_idx", 64'(dump_idx_o), 64'(0));
        end
        if (fresh) got[m_idx] = dump_data_o;
        if (m_done) dones++;
    endtask

    // mode 0: ready high, 1: 3-cycle stall on idx 5, 2: random ready + writes,
    // 3: extra start pulses while busy, 4: overwrite reg 20 before its fetch.
    task automatic run_dump(input int mode, output int rel_done, output int rel_first);
        int hold = 0;
        int t0 = cyc;
        bit st, rdy;
        rel_done = -1; rel_first = -1; words = 0;
        for (int k = 0; k < 400 && rel_done < 0; k++) begin
            st  = (k == 0) || (mode == 3 && (k == 10 || k == 40));
            rdy = 1'b1;
            if (mode == 1 && m_valid && m_idx == 5 && hold < 3) begin rdy = 1'b0; hold++; end
            if (mode == 2) begin
                rdy = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, NUM_REGS - 1)] = $urandom;
            end
            if (mode == 4 && m_valid && m_idx == 18) rf[20] = 32'hDEAD_BEEF;
            tick(st, rdy, 1'b0);
            if (m_valid && rel_first < 0) rel_first = cyc - t0;
            if (m_done) rel_done = cyc - t0;
        end
        chk("done_within_budget", 64'(rel_done >= 0), 64'(1));
    endtask

    initial begin
        int nw, rd, rf1, d0;
        nw = NUM_REGS - int'(FIRST_IDX);
        for (int i = 0; i < NUM_REGS; i++) rf[i] = 32'hA500_0000 + 32'(i);
        rf[0]  = '0;
        rf[29] = 32'h1001_00FC;
        reset = 1'b1; start_i = 1'b0; dump_ready_i = 1'b0;

        tick(1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0);

        // Full dump, ready held high.
        run_dump(0, rd, rf1);
        chk("full_words", 64'(words), 64'(nw));
        chk("full_first_valid", 64'(rf1), 64'(2));
        chk("full_done_cycle", 64'(rd), 64'(2 * nw + 1));
        chk("full_word29", 64'(got[29]), 64'(32'h1001_00FC));
        chk("full_word31", 64'(got[31]), 64'(32'hA500_001F));
        chk("full_first_idx_data", 64'(got[FIRST_IDX]), 64'(rf[FIRST_IDX]));
        tick(1'b0, 1'b1, 1'b0);

        // Backpressure on idx 5.
        run_dump(1, rd, rf1);
        chk("bp_word5", 64'(got[5]), 64'(32'hA500_0005));
        chk("bp_done_cycle", 64'(rd), 64'(2 * nw + 4));
        tick(1'b0, 1'b1, 1'b0);

        // Start pulses while busy must not queue a second dump.
        d0 = dones;
        run_dump(3, rd, rf1);
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b1, 1'b0);
        chk("busy_start_dones", 64'(dones - d0), 64'(1));
        chk("busy_start_words", 64'(words), 64'(nw));

        // Reset during SEND of idx 12, then a fresh dump.
        tick(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 100 && !(m_valid && m_idx == 12); k++) tick(1'b0, 1'b1, 1'b0);
        chk("reached_idx12", 64'(m_valid && m_idx == 12), 64'(1));
        tick(1'b0, 1'b0, 1'b1);
        chk("rst_mid_valid", 64'(dump_valid_o), 64'(0));
        chk("rst_mid_busy", 64'(busy_o), 64'(0));
        tick(1'b0, 1'b0, 1'b0);
        run_dump(0, rd, rf1);
        chk("restart_words", 64'(words), 64'(nw));
        chk("restart_done_cycle", 64'(rd), 64'(2 * nw + 1));
        tick(1'b0, 1'b1, 1'b0);

        // Register written mid-dump, before its fetch.
        run_dump(4, rd, rf1);
        chk("concurrent_word20", 64'(got[20]), 64'(32'hDEAD_BEEF));
        tick(1'b0, 1'b1, 1'b0);

        // Random ready and register traffic.
        for (int r = 0; r < 3; r++) begin
            run_dump(2, rd, rf1);
            chk("rand_words", 64'(words), 64'(nw));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
